imm_gen_stage: RTL and testbench
================================

# imm_gen_stage

Registered, parametrised immediate generator for the decode stage of the pipelined core. It supports RV32 and RV64 (XLEN), shift-amount and CSR-immediate formats, and reports an illegal-shift flag. Instructions arrive over a valid/ready handshake and pass through a 2-entry skid buffer. Output is a typed, sign-correct immediate plus a passthrough tag. Flush support lets the hazard unit drop in-flight entries.

## Interface
- XLEN, 32, immediate/datapath width; only 32 or 64 legal (elaboration error otherwise)
- INST_WIDTH, 32, instruction width
- TAG_WIDTH, 5, opaque sideband carried with each instruction
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  instruction offered
- in_ready  out  1  stage can accept
- in_instr  in  INST_WIDTH  instruction word
- in_tag  in  TAG_WIDTH  sideband
- flush  in  1  discard all held and incoming entries
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts
- out_imm  out  XLEN  extended immediate
- out_type  out  3  NONE=0 I=1 S=2 B=3 U=4 J=5 SH=6 Z=7
- out_illegal  out  1  malformed shift encoding
- out_tag  out  TAG_WIDTH  sideband of the presented entry

## Operation
- Decode, all results sign-extended from instr[31] to XLEN unless stated:
  - I-type: opcodes 0000011, 1100111, and 0010011 with funct3 not 001/101. Immediate is instr[31:20].
  - S-type: {instr[31:25], instr[11:7]}.
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}, a byte offset with bit 0 = 0.
  - J-type: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - U-type: 0110111 and 0010111. Immediate is {instr[31:12], 12'b0}; bits above 31 are sign-filled when XLEN=64.
- SH type:
  - Applies to 0010011 with funct3 001/101, and to 0011011 when XLEN=64.
  - Shamt is zero-extended: instr[25:20] for XLEN=64 on 0010011, otherwise instr[24:20].
  - out_illegal=1 when XLEN=32 and instr[25]=1. The immediate is still the 5-bit field.
- Opcode 0011011 with XLEN=32, and any unlisted opcode: type NONE, imm 0, illegal 0.
- Skid buffer:
  - Entries: main (drives outputs) and skid.
  - in_ready = ~skid_valid, driven straight from the register.
  - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
  - If main is empty or draining this cycle, the input loads main. Otherwise it loads skid.
  - When main drains and skid is full, skid moves into main.
  - Order is strictly FIFO. No entry is ever lost or duplicated.
- flush: both entries are invalidated at the next edge. Any input transfer in the same cycle is discarded. Flush dominates all simultaneous events.

## Timing
- Reset values: out_valid=0, out_imm=0, out_type=0, out_illegal=0, out_tag=0, in_ready=1.
- Reset asserted mid-operation clears both entries immediately (asynchronously).
- Latency: one cycle from accepted input to out_valid when the buffer is empty.
- Throughput: one per cycle with out_ready held high.
- in_ready falls the cycle after skid fills. It rises the cycle after skid empties.
- Outputs are held stable while out_valid=1 and out_ready=0.
- After flush, out_valid=0 and in_ready=1 in the following cycle.

## Configuration
- IMM_GEN_CSR_EN defined: SYSTEM opcode 1110011 decodes as follows.
  - funct3[2]=1 gives type Z, imm = instr[19:15] zero-extended.
  - funct3 001/010/011 gives type I, with the immediate taken from instr[31:20].
  - funct3 000 gives NONE.
- IMM_GEN_CSR_EN undefined: opcode 1110011 gives NONE, imm 0. Code 7 is never produced.

## Structure
- Shared package imm_pkg holds:
  - the imm_type enum/constants (3 bits)
  - RV opcode localparams: LOAD, OP_IMM, OP_IMM_32, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM
  - funct3 shift codes
- Sub-module imm_decode: purely combinational. Takes instr and produces imm, type and illegal, parametrised by XLEN.
- imm_gen_stage owns only the skid buffer and flush logic.

## Test plan
- XLEN=32, 0xFFF00093 (addi -1), out_ready=1 → next cycle out_valid=1, imm 0xFFFFFFFF, type I.
- 0xFE000EE3 (beq -4) → imm 0xFFFFFFFC, type B. XLEN=64 → 0xFFFFFFFFFFFFFFFC.
- XLEN=64, 0x800000B7 (lui 0x80000) → imm 0xFFFFFFFF80000000, type U.
- 0x02009093 (slli 32):
  - XLEN=32 → type SH, illegal 1, imm 0.
  - XLEN=64 → imm 32, illegal 0.
- Backpressure: out_ready=0, in_valid=1 with tags 1,2,3 over three cycles.
  - Tags 1 and 2 are accepted; in_ready=0 from cycle 3.
  - Raising out_ready then yields tags 1, 2 and then 3 in order.
- Both entries full, then flush with in_valid=1 → next cycle out_valid=0, in_ready=1, and the offered instruction never appears.
- rst pulsed mid-stream → all outputs return to their reset values immediately.
- 0x300FD073 (csrrwi, zimm 31):
  - with IMM_GEN_CSR_EN → type Z, imm 31.
  - without IMM_GEN_CSR_EN → type NONE, imm 0.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate generator: immediate type codes,
// RV base opcodes and the funct3 codes that mark shift-immediates.
package imm_pkg;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5,
      IMM_SH   = 3'd6,
      IMM_Z    = 3'd7
   } imm_type_e;

   localparam logic [6:0] LOAD      = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] STORE     = 7'b0100011;
   localparam logic [6:0] BRANCH    = 7'b1100011;
   localparam logic [6:0] JAL       = 7'b1101111;
   localparam logic [6:0] JALR      = 7'b1100111;
   localparam logic [6:0] LUI       = 7'b0110111;
   localparam logic [6:0] AUIPC     = 7'b0010111;
   localparam logic [6:0] SYSTEM    = 7'b1110011;

   localparam logic [2:0] F3_SLL = 3'b001;
   localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder. Produces the XLEN-wide immediate, its
// type code and the malformed-shift flag for one instruction word.
// Optional feature: define IMM_GEN_CSR_EN to decode SYSTEM-opcode immediates.
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      imm_type,
   output logic            illegal
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_decode: XLEN must be 32 or 64");
   end

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] imm32;
   logic        zext;
   imm_type_e   ty;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];

   // Build a 32-bit immediate and note whether it is zero- or sign-extended.
   always_comb begin
      imm32   = '0;
      ty      = IMM_NONE;
      illegal = 1'b0;
      zext    = 1'b0;
      case (opcode)
         LOAD, JALR: begin
            ty    = IMM_I;
            imm32 = {{20{instr[31]}}, instr[31:20]};
         end
         OP_IMM: begin
            if (funct3 == F3_SLL || funct3 == F3_SR) begin
               ty   = IMM_SH;
               zext = 1'b1;
               if (XLEN == 64) begin
                  imm32 = {26'b0, instr[25:20]};
               end else begin
                  // RV32 shamt is 5 bits; bit 25 set is a malformed encoding.
                  imm32   = {27'b0, instr[24:20]};
                  illegal = instr[25];
               end
            end else begin
               ty    = IMM_I;
               imm32 = {{20{instr[31]}}, instr[31:20]};
            end
         end
         OP_IMM_32: begin
            if (XLEN == 64) begin
               ty    = IMM_SH;
               zext  = 1'b1;
               imm32 = {27'b0, instr[24:20]};
            end
         end
         STORE: begin
            ty    = IMM_S;
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         end
         BRANCH: begin
            ty    = IMM_B;
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         JAL: begin
            ty    = IMM_J;
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         LUI, AUIPC: begin
            ty    = IMM_U;
            imm32 = {instr[31:12], 12'b0};
         end
`ifdef IMM_GEN_CSR_EN
         SYSTEM: begin
            if (funct3[2]) begin
               ty    = IMM_Z;
               zext  = 1'b1;
               imm32 = {27'b0, instr[19:15]};
            end else if (funct3 != 3'b000) begin
               ty    = IMM_I;
               imm32 = {{20{instr[31]}}, instr[31:20]};
            end
         end
`endif
         default: begin
            ty = IMM_NONE;
         end
      endcase
   end

   assign imm      = zext ? XLEN'(imm32) : XLEN'($signed(imm32));
   assign imm_type = ty;

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate generator stage: decodes on the input side and holds
// results in a two-entry skid buffer (main drives the outputs, skid catches
// the one extra beat accepted while main is stalled).
// Handshake: a beat moves on any rising edge where valid and ready are both
// high; valid holds its data stable until that edge; ready never depends
// combinationally on valid.
// Optional feature: define IMM_GEN_CSR_EN to decode SYSTEM-opcode immediates.
module imm_gen_stage
   import imm_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int INST_WIDTH = 32,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [INST_WIDTH-1:0] in_instr,
   input  logic [TAG_WIDTH-1:0]  in_tag,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_imm,
   output logic [2:0]            out_type,
   output logic                  out_illegal,
   output logic [TAG_WIDTH-1:0]  out_tag
);

   logic [XLEN-1:0]      dec_imm;
   logic [2:0]           dec_type;
   logic                 dec_illegal;

   logic                 main_valid;
   logic [XLEN-1:0]      main_imm;
   logic [2:0]           main_type;
   logic                 main_illegal;
   logic [TAG_WIDTH-1:0] main_tag;

   logic                 skid_valid;
   logic [XLEN-1:0]      skid_imm;
   logic [2:0]           skid_type;
   logic                 skid_illegal;
   logic [TAG_WIDTH-1:0] skid_tag;

   logic                 in_xfer;
   logic                 main_free;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr    (in_instr[31:0]),
      .imm      (dec_imm),
      .imm_type (dec_type),
      .illegal  (dec_illegal)
   );

   assign in_ready  = ~skid_valid;
   assign in_xfer   = in_valid & in_ready;
   // Main can take a new entry when it is empty or handing its entry off now.
   assign main_free = ~main_valid | out_ready;

   // Skid buffer update; flush drops everything, including this cycle's input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid   <= 1'b0;
         main_imm     <= '0;
         main_type    <= '0;
         main_illegal <= 1'b0;
         main_tag     <= '0;
         skid_valid   <= 1'b0;
         skid_imm     <= '0;
         skid_type    <= '0;
         skid_illegal <= 1'b0;
         skid_tag     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (main_free) begin
         if (skid_valid) begin
            // Input is blocked whenever skid is full, so only skid moves here.
            main_valid   <= 1'b1;
            main_imm     <= skid_imm;
            main_type    <= skid_type;
            main_illegal <= skid_illegal;
            main_tag     <= skid_tag;
            skid_valid   <= 1'b0;
         end else if (in_xfer) begin
            main_valid   <= 1'b1;
            main_imm     <= dec_imm;
            main_type    <= dec_type;
            main_illegal <= dec_illegal;
            main_tag     <= in_tag;
         end else begin
            main_valid <= 1'b0;
         end
      end else if (in_xfer) begin
         skid_valid   <= 1'b1;
         skid_imm     <= dec_imm;
         skid_type    <= dec_type;
         skid_illegal <= dec_illegal;
         skid_tag     <= in_tag;
      end
   end

   assign out_valid   = main_valid;
   assign out_imm     = main_imm;
   assign out_type    = main_type;
   assign out_illegal = main_illegal;
   assign out_tag     = main_tag;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: one RV32 and one RV64 instance share the
// same stimulus; expected values are hand-computed constants.
module tb_imm_gen_stage;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [4:0]  in_tag;
   logic        flush;
   logic        out_ready;

   logic        in_ready_32, out_valid_32, out_illegal_32;
   logic [31:0] out_imm_32;
   logic [2:0]  out_type_32;
   logic [4:0]  out_tag_32;

   logic        in_ready_64, out_valid_64, out_illegal_64;
   logic [63:0] out_imm_64;
   logic [2:0]  out_type_64;
   logic [4:0]  out_tag_64;

   int compared;
   int mismatched;
   logic [4:0] exp_q[$];

   imm_gen_stage #(.XLEN(32), .INST_WIDTH(32), .TAG_WIDTH(5)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_32),
      .in_instr(in_instr), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid_32), .out_ready(out_ready), .out_imm(out_imm_32),
      .out_type(out_type_32), .out_illegal(out_illegal_32), .out_tag(out_tag_32)
   );

   imm_gen_stage #(.XLEN(64), .INST_WIDTH(32), .TAG_WIDTH(5)) dut64 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_64),
      .in_instr(in_instr), .in_tag(in_tag), .flush(flush),
      .out_valid(out_valid_64), .out_ready(out_ready), .out_imm(out_imm_64),
      .out_type(out_type_64), .out_illegal(out_illegal_64), .out_tag(out_tag_64)
   );

   // Clock generation.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
      end
   endtask

   // Checks one decoded result on both instances.
   task automatic check_out(input string name, input logic [4:0] tag,
                            input logic [31:0] imm32, input logic [2:0] ty32, input logic ill32,
                            input logic [63:0] imm64, input logic [2:0] ty64, input logic ill64);
      check({name, " valid32"}, 64'(out_valid_32), 64'd1);
      check({name, " tag32"},   64'(out_tag_32),   64'(tag));
      check({name, " imm32"},   64'(out_imm_32),   64'(imm32));
      check({name, " type32"},  64'(out_type_32),  64'(ty32));
      check({name, " ill32"},   64'(out_illegal_32), 64'(ill32));
      check({name, " valid64"}, 64'(out_valid_64), 64'd1);
      check({name, " imm64"},   out_imm_64,        imm64);
      check({name, " type64"},  64'(out_type_64),  64'(ty64));
      check({name, " ill64"},   64'(out_illegal_64), 64'(ill64));
   endtask

   task automatic check_reset_values(input string name);
      check({name, " out_valid"},   64'(out_valid_32),   64'd0);
      check({name, " out_imm"},     64'(out_imm_32),     64'd0);
      check({name, " out_type"},    64'(out_type_32),    64'd0);
      check({name, " out_illegal"}, 64'(out_illegal_32), 64'd0);
      check({name, " out_tag"},     64'(out_tag_32),     64'd0);
      check({name, " in_ready"},    64'(in_ready_32),    64'd1);
      check({name, " out_valid64"}, 64'(out_valid_64),   64'd0);
      check({name, " out_imm64"},   out_imm_64,          64'd0);
   endtask

   initial begin
      int budget;
      logic accept;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_tag    = '0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // Reset state.
      step();
      step();
      check_reset_values("reset");
      rst = 1'b0;
      step();

      // Decode stream at one per cycle, out_ready held high.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_instr = 32'hFFF00093; in_tag = 5'd1; step();
      check_out("addi", 5'd1, 32'hFFFFFFFF, 3'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0);
      in_instr = 32'hFE000EE3; in_tag = 5'd2; step();
      check_out("beq", 5'd2, 32'hFFFFFFFC, 3'd3, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
      in_instr = 32'h800000B7; in_tag = 5'd3; step();
      check_out("lui", 5'd3, 32'h80000000, 3'd4, 1'b0, 64'hFFFFFFFF80000000, 3'd4, 1'b0);
      in_instr = 32'h02009093; in_tag = 5'd4; step();
      check_out("slli32", 5'd4, 32'h0, 3'd6, 1'b1, 64'd32, 3'd6, 1'b0);
      in_instr = 32'h00112623; in_tag = 5'd5; step();
      check_out("sw", 5'd5, 32'd12, 3'd2, 1'b0, 64'd12, 3'd2, 1'b0);
      in_instr = 32'hFFDFF06F; in_tag = 5'd6; step();
      check_out("jal", 5'd6, 32'hFFFFFFFC, 3'd5, 1'b0, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0);
      in_instr = 32'h0000007F; in_tag = 5'd7; step();
      check_out("unknown", 5'd7, 32'h0, 3'd0, 1'b0, 64'h0, 3'd0, 1'b0);
      in_instr = 32'h0000001B; in_tag = 5'd8; step();
      check_out("opimm32", 5'd8, 32'h0, 3'd0, 1'b0, 64'h0, 3'd6, 1'b0);
      in_instr = 32'h300FD073; in_tag = 5'd9; step();
`ifdef IMM_GEN_CSR_EN
      check_out("csrrwi", 5'd9, 32'd31, 3'd7, 1'b0, 64'd31, 3'd7, 1'b0);
`else
      check_out("csrrwi", 5'd9, 32'd0, 3'd0, 1'b0, 64'd0, 3'd0, 1'b0);
`endif
      in_valid = 1'b0;
      step();
      check("drained valid", 64'(out_valid_32), 64'd0);

      // Backpressure: tags 1 and 2 accepted, tag 3 held off until space frees.
      out_ready = 1'b0;
      in_instr  = 32'hFFF00093;
      in_valid  = 1'b1;
      in_tag    = 5'd1;
      exp_q.push_back(5'd1);
      exp_q.push_back(5'd2);
      exp_q.push_back(5'd3);
      step();
      check("bp in_ready c1", 64'(in_ready_32), 64'd1);
      in_tag = 5'd2;
      step();
      check("bp in_ready c2", 64'(in_ready_32), 64'd0);
      in_tag = 5'd3;
      step();
      check("bp in_ready c3", 64'(in_ready_32), 64'd0);
      check("bp held tag", 64'(out_tag_32), 64'd1);
      out_ready = 1'b1;
      budget = 10;
      while (exp_q.size() > 0 && budget > 0) begin
         if (out_valid_32) begin
            check("bp order", 64'(out_tag_32), 64'(exp_q.pop_front()));
         end
         accept = in_valid & in_ready_32;
         step();
         if (accept) in_valid = 1'b0;
         budget--;
      end
      check("bp all delivered", 64'(exp_q.size()), 64'd0);
      check("bp no duplicate", 64'(out_valid_32), 64'd0);

      // Flush with both entries full and a beat offered.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_tag    = 5'd10; step();
      in_tag    = 5'd11; step();
      check("fl full in_ready", 64'(in_ready_32), 64'd0);
      flush  = 1'b1;
      in_tag = 5'd12;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("fl out_valid", 64'(out_valid_32), 64'd0);
      check("fl in_ready", 64'(in_ready_32), 64'd1);
      out_ready = 1'b1;
      step();
      check("fl stays empty", 64'(out_valid_32), 64'd0);

      // Flush with main full and input accepted the same cycle.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_tag    = 5'd13; step();
      flush  = 1'b1;
      in_tag = 5'd14;
      step();
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("fl2 out_valid", 64'(out_valid_32), 64'd0);
      step();
      check("fl2 input dropped", 64'(out_valid_32), 64'd0);

      // Asynchronous reset mid-stream.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = 32'hFE000EE3;
      in_tag    = 5'd20; step();
      in_tag    = 5'd21; step();
      check("pre-rst valid", 64'(out_valid_32), 64'd1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("async rst");
      in_valid = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("post-rst valid", 64'(out_valid_32), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
